// File: rtl/dcache_ctrl_if.sv
// CPU load/store and memory port-2 / MMIO signal bundle for dcache_ctrl.
// master: CPU + memory side (drives requests and read data).
// slave:  the cache controller.
interface dcache_ctrl_if;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [31:0] CPU_ADDR;
    logic [3:0]  CPU_BE;
    logic [31:0] CPU_WDATA;
    logic [31:0] CPU_RDATA;
    logic        CPU_READY;
    logic        MEM_READ2;
    logic        MEM_WRITE2;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic [31:0] MEM_DOUT2;
    logic        MEM_MMIOREAD;
    logic        MEM_MMIOWRITE;
    logic [31:0] MEM_ADDR2BYPASS;
    logic [31:0] MEM_DOUT2BYPASS;

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_BE, CPU_WDATA, MEM_DOUT2, MEM_DOUT2BYPASS,
        input  CPU_RDATA, CPU_READY, MEM_READ2, MEM_WRITE2, MEM_ADDR2, MEM_DIN2,
               MEM_MMIOREAD, MEM_MMIOWRITE, MEM_ADDR2BYPASS
    );

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_BE, CPU_WDATA, MEM_DOUT2, MEM_DOUT2BYPASS,
        output CPU_RDATA, CPU_READY, MEM_READ2, MEM_WRITE2, MEM_ADDR2, MEM_DIN2,
               MEM_MMIOREAD, MEM_MMIOWRITE, MEM_ADDR2BYPASS
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete with zero wait states; misses write back a dirty victim and
// fill the line word by word; addresses >= MMIO_BASE bypass the cache.
// Optional hit/miss counters: define DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INDEX_BITS = 6,
    parameter logic [31:0] MMIO_BASE  = 32'h11000000
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef DCACHE_STATS_EN
    output logic [31:0] STAT_HITS,
    output logic [31:0] STAT_MISSES,
`endif
    dcache_ctrl_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - OFF_W - INDEX_BITS;
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam int unsigned DA_W  = INDEX_BITS + OFF_W;
    localparam int unsigned DEPTH = 1 << DA_W;

    typedef enum logic [1:0] {S_IDLE, S_MMIO_WAIT, S_WRITEBACK, S_FILL} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, dirty_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [31:0]           data_q [DEPTH];
    logic [CNT_W-1:0]      cnt_q;
    logic [TAG_W-1:0]      miss_tag_q;
    logic [INDEX_BITS-1:0] miss_idx_q;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [OFF_W-1:0]      req_word;
    logic [OFF_W-1:0]      cnt_word, cap_word;
    logic is_mmio, hit, victim_dirty, req_cached, hit_go, miss_go, store_go;
    logic wb_last, fill_last, fill_capture;
    logic unused_addr_bits;

    // Address decode and hit detection
    assign req_word     = bus.CPU_ADDR[2 +: OFF_W];
    assign req_idx      = bus.CPU_ADDR[2 + OFF_W +: INDEX_BITS];
    assign req_tag      = bus.CPU_ADDR[31 -: TAG_W];
    assign unused_addr_bits = ^bus.CPU_ADDR[1:0];
    assign is_mmio      = bus.CPU_ADDR >= MMIO_BASE;
    assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
    assign req_cached   = (state_q == S_IDLE) && bus.CPU_REQ && !is_mmio;
    assign hit_go       = req_cached && hit;
    assign miss_go      = req_cached && !hit;
    assign store_go     = hit_go && bus.CPU_WE;
    assign cnt_word     = cnt_q[OFF_W-1:0];
    assign cap_word     = OFF_W'(cnt_q - CNT_W'(1));
    assign wb_last      = (state_q == S_WRITEBACK) && (cnt_q == CNT_W'(LINE_WORDS - 1));
    assign fill_last    = (state_q == S_FILL) && (cnt_q == CNT_W'(LINE_WORDS));
    assign fill_capture = (state_q == S_FILL) && (cnt_q != '0);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.CPU_REQ) begin
                    if (is_mmio)   state_d = S_MMIO_WAIT;
                    else if (!hit) state_d = victim_dirty ? S_WRITEBACK : S_FILL;
                end
            end
            S_MMIO_WAIT: state_d = S_IDLE;
            S_WRITEBACK: if (wb_last)   state_d = S_FILL;
            S_FILL:      if (fill_last) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output logic; everything is held at zero while RST is asserted
    always_comb begin
        bus.CPU_READY       = 1'b0;
        bus.CPU_RDATA       = '0;
        bus.MEM_READ2       = 1'b0;
        bus.MEM_WRITE2      = 1'b0;
        bus.MEM_ADDR2       = '0;
        bus.MEM_DIN2        = '0;
        bus.MEM_MMIOREAD    = 1'b0;
        bus.MEM_MMIOWRITE   = 1'b0;
        bus.MEM_ADDR2BYPASS = '0;
        if (!RST) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.CPU_REQ) begin
                        if (is_mmio) begin
                            bus.MEM_MMIOREAD    = !bus.CPU_WE;
                            bus.MEM_MMIOWRITE   = bus.CPU_WE;
                            bus.MEM_ADDR2BYPASS = bus.CPU_ADDR;
                            bus.MEM_DIN2        = bus.CPU_WDATA;
                        end else if (hit) begin
                            bus.CPU_READY = 1'b1;
                            if (!bus.CPU_WE) bus.CPU_RDATA = data_q[{req_idx, req_word}];
                        end
                    end
                end
                S_MMIO_WAIT: begin
                    bus.CPU_READY = 1'b1;
                    bus.CPU_RDATA = bus.MEM_DOUT2BYPASS;
                end
                S_WRITEBACK: begin
                    bus.MEM_WRITE2 = 1'b1;
                    bus.MEM_ADDR2  = {tag_q[miss_idx_q], miss_idx_q, cnt_word, 2'b00};
                    bus.MEM_DIN2   = data_q[{miss_idx_q, cnt_word}];
                end
                S_FILL: begin
                    if (cnt_q < CNT_W'(LINE_WORDS)) begin
                        bus.MEM_READ2 = 1'b1;
                        bus.MEM_ADDR2 = {miss_tag_q, miss_idx_q, cnt_word, 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

    // Word counter for writeback/fill, restarted on every state change
    always_ff @(posedge CLK) begin
        if (RST)                                               cnt_q <= '0;
        else if (state_d != state_q)                           cnt_q <= '0;
        else if (state_q == S_WRITEBACK || state_q == S_FILL)  cnt_q <= cnt_q + CNT_W'(1);
    end

    // Latch the missing line so a dropped request cannot disturb the fill
    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else if (miss_go) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
        end
    end

    // Valid/dirty bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (store_go)  dirty_q[req_idx]    <= 1'b1;
            if (wb_last)   dirty_q[miss_idx_q] <= 1'b0;
            if (fill_last) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag array, written when a fill completes
    always_ff @(posedge CLK) begin
        if (!RST && fill_last) tag_q[miss_idx_q] <= miss_tag_q;
    end

    // Data array: fill capture (one cycle behind the read strobe) and byte-masked store hits
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (fill_capture) data_q[{miss_idx_q, cap_word}] <= bus.MEM_DOUT2;
            if (store_go) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.CPU_BE[b]) data_q[{req_idx, req_word}][8*b +: 8] <= bus.CPU_WDATA[8*b +: 8];
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic fill_done_q;

    // Saturating hit/miss counters; the retry hit right after a fill is not a hit
    always_ff @(posedge CLK) begin
        if (RST) begin
            STAT_HITS   <= '0;
            STAT_MISSES <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= fill_last;
            if (hit_go && !fill_done_q && (STAT_HITS != 32'hFFFFFFFF)) STAT_HITS <= STAT_HITS + 32'd1;
            if (miss_go && (STAT_MISSES != 32'hFFFFFFFF))              STAT_MISSES <= STAT_MISSES + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller sitting between the CPU load/store unit and the data port (port 2) of the dual-port main memory.
- Serves hits with zero wait states.
- On a miss, writes back a dirty victim line, then fills the new line word by word over the memory's 1-cycle synchronous read port.
- Addresses >= MMIO_BASE bypass the cache and are forwarded on the memory's MMIO strobes.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of 2, >= 2.
- INDEX_BITS, 6, line-index width (64 lines, 1 KB at default).
- MMIO_BASE, 32'h11000000, first uncached address; unsigned compare.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- CPU_REQ  in  1  request valid; CPU holds all CPU_* inputs stable until CPU_READY.
- CPU_WE  in  1  1 = store, 0 = load.
- CPU_ADDR  in  32  byte address; word-aligned.
- CPU_BE  in  4  store byte enables.
- CPU_WDATA  in  32  store data.
- CPU_RDATA  out  32  load data; valid when CPU_READY=1 and CPU_WE=0.
- CPU_READY  out  1  request completes this cycle.
- MEM_READ2  out  1  memory port-2 read strobe.
- MEM_WRITE2  out  1  memory port-2 write strobe.
- MEM_ADDR2  out  32  memory port-2 byte address.
- MEM_DIN2  out  32  memory write data; also MMIO write data.
- MEM_DOUT2  in  32  memory read data, valid the cycle after MEM_READ2.
- MEM_MMIOREAD  out  1  MMIO read strobe.
- MEM_MMIOWRITE  out  1  MMIO write strobe.
- MEM_ADDR2BYPASS  out  32  MMIO address.
- MEM_DOUT2BYPASS  in  32  MMIO read data, valid the cycle after MEM_MMIOREAD.

Behaviour:
- Address split: [1:0] byte offset; word = [log2(LINE_WORDS)+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage: per line, valid, dirty, tag and LINE_WORDS data words.
  - Tag/valid/dirty are flop arrays.
  - Data may be flops or LUTRAM but must support a combinational read.
- Reset: all valid and dirty bits cleared; data arrays not reset; state = IDLE.
  - All strobes, CPU_READY, CPU_RDATA and MEM_* address/data outputs are 0.
- IDLE, no request: all strobes 0.
- IDLE, CPU_REQ=1, CPU_ADDR >= MMIO_BASE:
  - Drive MEM_ADDR2BYPASS = CPU_ADDR and MEM_DIN2 = CPU_WDATA.
  - Assert MEM_MMIOREAD = !CPU_WE or MEM_MMIOWRITE = CPU_WE for exactly one cycle.
  - Go to MMIO_WAIT.
- MMIO_WAIT: CPU_READY=1; CPU_RDATA = MEM_DOUT2BYPASS; go to IDLE. No cache state changes.
- IDLE, CPU_REQ=1, hit (valid and tag match):
  - CPU_READY=1 in the same cycle.
  - Load: CPU_RDATA = line word.
  - Store: bytes selected by CPU_BE are written at the clock edge and dirty is set.
- IDLE, CPU_REQ=1, miss:
  - Go to WRITEBACK if the victim is valid and dirty, else FILL. CPU_READY=0.
- WRITEBACK: LINE_WORDS cycles, word k = 0..LINE_WORDS-1.
  - MEM_WRITE2=1; MEM_ADDR2 = {victim tag, index, k, 2'b00}; MEM_DIN2 = victim word k.
  - Then clear dirty and go to FILL.
- FILL: LINE_WORDS+1 cycles.
  - Cycle k < LINE_WORDS: MEM_READ2=1, MEM_ADDR2 = {new tag, index, k, 2'b00}.
  - Cycle k >= 1: capture MEM_DOUT2 into word k-1.
  - On the last cycle: write tag, valid=1, dirty=0; go to IDLE.
  - The held request then hits on the next cycle.
- Miss latency (request cycle to CPU_READY):
  - Clean victim: LINE_WORDS+2 cycles.
  - Dirty victim: 2*LINE_WORDS+2 cycles.
- Strobe rules: MEM_READ2 and MEM_WRITE2 are never high together. Memory strobes are never asserted during MMIO states, and MMIO strobes are never asserted during cache states.
- Boundaries:
  - CPU_REQ dropping mid-miss: the fill still completes, with no CPU_READY.
  - Index 2^INDEX_BITS-1 and word LINE_WORDS-1 address correctly with no wrap into the next line.
  - CPU_ADDR = MMIO_BASE-4 is cached; CPU_ADDR = MMIO_BASE is MMIO.
  - RST mid-WRITEBACK or mid-FILL: abort immediately to IDLE with all lines invalid; a partially written-back line is lost (accepted).

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, add outputs STAT_HITS[31:0] and STAT_MISSES[31:0], cleared by RST.
  - STAT_HITS increments once per cached request completing with no miss.
  - STAT_MISSES increments once per IDLE->WRITEBACK/FILL transition.
  - MMIO accesses are not counted; counters saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters do not exist.

Test Plan:
- Cold load at 0x100 after reset, memory words 0x100..0x10C = 0xA0..0xA3 -> four MEM_READ2 cycles at 0x100..0x10C, CPU_READY on cycle 6, CPU_RDATA = 0xA0; a following load at 0x108 returns 0xA2 with zero wait.
- Store 0xDEADBEEF with BE=4'b0011 to cached 0x104 (old 0x11111111) -> load returns 0x1111BEEF; no MEM_WRITE2 issued.
- Dirty line at 0x104, then load 0x504 (same index, default params) -> four MEM_WRITE2 cycles at 0x100..0x10C carrying 0x1111BEEF at 0x104, then fill; ready on cycle 10.
- Load 0x11000010 with MEM_DOUT2BYPASS = 0x55 -> one-cycle MEM_MMIOREAD, MEM_ADDR2BYPASS = 0x11000010, CPU_READY next cycle with 0x55, no MEM_READ2; a store there gives one MEM_MMIOWRITE pulse with MEM_DIN2 = data.
- RST asserted during FILL cycle 2 -> state IDLE, all strobes 0 next cycle; a subsequent load to the same address misses again.
- With DCACHE_STATS_EN: miss, hit, hit, MMIO -> STAT_HITS = 2 (the completion of the miss retry is not counted), STAT_MISSES = 1.
